// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory-stall control bundle between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RD_i;
  logic [4:0]  IFID_RS1_i;
  logic [4:0]  IFID_RS2_i;
  logic        Branch_i;
  logic        MemReq_i;
  logic        MemAck_i;
  logic        PC_Write_o;
  logic        IFID_Write_o;
  logic        IFID_Flush_o;
  logic        IDEX_Bubble_o;
  logic        MemStall_o;
  logic        Mem_Enable_o;
  logic        Err_o;
  logic [15:0] MemStallCnt_o;
  logic [15:0] LoadUseCnt_o;
  logic [15:0] FlushCnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RD_i, IFID_RS1_i, IFID_RS2_i, Branch_i, MemReq_i, MemAck_i,
    input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, MemStall_o, Mem_Enable_o,
           Err_o, MemStallCnt_o, LoadUseCnt_o, FlushCnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RD_i, IFID_RS1_i, IFID_RS2_i, Branch_i, MemReq_i, MemAck_i,
    output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, MemStall_o, Mem_Enable_o,
           Err_o, MemStallCnt_o, LoadUseCnt_o, FlushCnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: data-memory stall FSM with timeout, load-use bubble,
// branch flush, and saturating event counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipeline_ctrl_if.slave   bus
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_q;
  logic               err_q;
  logic [CNT_W-1:0]   ms_cnt_q, lu_cnt_q, fl_cnt_q;

  logic mem_stall_c, mem_en_c, load_use_c, timeout_c;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

  // Abort on the TIMEOUT-th WAIT cycle; an ack in that same cycle still wins.
  assign timeout_c = (state_q == ST_WAIT) && !bus.MemAck_i &&
                     (wait_q == WCNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.MemReq_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.MemAck_i)  state_d = ST_DONE;
        else if (timeout_c) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.MemReq_i) wait_q <= '0;
      else if (state_q == ST_WAIT)            wait_q <= wait_q + WCNT_W'(1);
      if (timeout_c) err_q <= 1'b1;
    end
  end

  assign load_use_c = bus.IDEX_MemRead_i && (bus.IDEX_RD_i != 5'd0) &&
                      ((bus.IDEX_RD_i == bus.IFID_RS1_i) || (bus.IDEX_RD_i == bus.IFID_RS2_i));

  // Memory stall beats load-use beats branch; a frozen pipe holds the branch for later.
  always_comb begin
    mem_en_c      = 1'b0;
    mem_stall_c   = 1'b0;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if ((state_q == ST_IDLE && bus.MemReq_i) || state_q == ST_WAIT) begin
      mem_en_c    = 1'b1;
      mem_stall_c = 1'b1;
    end
    if (mem_stall_c) begin
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
    end else if (load_use_c) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end else if (bus.Branch_i) begin
      ifid_flush_c = 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ms_cnt_q <= '0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (mem_stall_c   && ms_cnt_q != '1) ms_cnt_q <= ms_cnt_q + CNT_W'(1);
      if (idex_bubble_c && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      if (ifid_flush_c  && fl_cnt_q != '1) fl_cnt_q <= fl_cnt_q + CNT_W'(1);
    end
  end

  assign bus.Mem_Enable_o  = mem_en_c;
  assign bus.MemStall_o    = mem_stall_c;
  assign bus.PC_Write_o    = pc_write_c;
  assign bus.IFID_Write_o  = ifid_write_c;
  assign bus.IFID_Flush_o  = ifid_flush_c;
  assign bus.IDEX_Bubble_o = idex_bubble_c;
  assign bus.Err_o         = err_q;
  assign bus.MemStallCnt_o = ms_cnt_q;
  assign bus.LoadUseCnt_o  = lu_cnt_q;
  assign bus.FlushCnt_o    = fl_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT-state cycles before memory-timeout abort.

Interface
REQ-002 The block SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst_i, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have IDEX_MemRead_i, input, 1, the load flag of the ID/EX stage.
REQ-005 The block SHALL have IDEX_RD_i, input, 5, the destination register of the ID/EX stage.
REQ-006 The block SHALL have IFID_RS1_i and IFID_RS2_i, inputs, 5 each, the source registers of the instruction in ID.
REQ-007 The block SHALL have Branch_i, input, 1, meaning a branch resolved taken in ID.
REQ-008 The block SHALL have MemReq_i, input, 1, meaning the MEM-stage instruction accesses data memory.
REQ-009 The block SHALL have MemAck_i, input, 1, the data-memory completion pulse.
REQ-010 The block SHALL have PC_Write_o, IFID_Write_o, IFID_Flush_o and IDEX_Bubble_o, outputs, 1 each, the PC/IF-ID enables, the IF/ID squash, and the ID/EX NOP-insert.
REQ-011 The block SHALL have MemStall_o, output, 1, the freeze of all stage registers (drives the ID/EX MemStall input).
REQ-012 The block SHALL have Mem_Enable_o, output, 1, the request to data memory.
REQ-013 The block SHALL have Err_o, output, 1, the sticky memory-timeout flag.
REQ-014 The block SHALL have MemStallCnt_o, LoadUseCnt_o and FlushCnt_o, outputs, 16 each, event counters.

Function
REQ-015 Memory FSM states SHALL be IDLE, WAIT and DONE.
REQ-016 IDLE: MemReq_i=1 -> WAIT; else stay.
REQ-017 WAIT: MemAck_i=1 -> DONE; a wait count reaching TIMEOUT without ack -> IDLE with Err_o set; else stay.
REQ-018 DONE SHALL last exactly one cycle then go to IDLE, and MemReq_i SHALL be ignored in DONE (no reissue for the completed access).
REQ-019 Mem_Enable_o SHALL be combinational: 1 in IDLE with MemReq_i=1, and 1 throughout WAIT; 0 otherwise.
REQ-020 MemStall_o SHALL be combinational: 1 in IDLE with MemReq_i=1, and 1 in WAIT; 0 in DONE, so the pipeline advances on the ack-plus-one edge.
REQ-021 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-022 Load-use SHALL be IDEX_MemRead_i and IDEX_RD_i!=0 and (IDEX_RD_i==IFID_RS1_i or IDEX_RD_i==IFID_RS2_i).
REQ-023 Output priority SHALL be MemStall, then load-use, then Branch_i.
REQ-024 MemStall_o=1 SHALL force PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0 and IFID_Flush_o=0; the branch stays held in frozen IF/ID and is re-evaluated later.
REQ-025 Load-use without MemStall SHALL give PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 and IFID_Flush_o=0.
REQ-026 Branch_i without MemStall or load-use SHALL give IFID_Flush_o=1 with PC_Write_o=1 and IFID_Write_o=1.
REQ-027 Default output values SHALL be PC_Write_o=1, IFID_Write_o=1, IFID_Flush_o=0 and IDEX_Bubble_o=0.
REQ-028 Each counter SHALL increment once per cycle in which its condition (MemStall_o, IDEX_Bubble_o or IFID_Flush_o) is 1, saturating at 16'hFFFF.
REQ-029 Err_o SHALL clear only on reset.

Reset
REQ-030 On rst_i=0 the block SHALL go immediately to IDLE with the wait counter, all counters and Err_o at 0; with MemReq_i=0, Mem_Enable_o=0, MemStall_o=0, PC_Write_o=1 and IFID_Write_o=1.
REQ-031 Reset asserted in WAIT SHALL drop Mem_Enable_o in the same cycle; an ack arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-032 Load-use: IDEX_MemRead_i=1, IDEX_RD_i=5, IFID_RS2_i=5 -> one cycle of PC_Write_o=0, IDEX_Bubble_o=1; LoadUseCnt_o=1.
REQ-033 Load-use with x0: IDEX_RD_i=0, IFID_RS1_i=0, IDEX_MemRead_i=1 -> no bubble, LoadUseCnt_o=0.
REQ-034 Memory access: MemReq_i=1, MemAck_i after 3 WAIT cycles -> MemStall_o=1 for 4 cycles, then 0 in DONE; MemStallCnt_o=4; no reissue in DONE.
REQ-035 Stall versus branch: MemReq_i=1 with Branch_i=1 -> IFID_Flush_o=0 while stalled, then 1 in the DONE cycle; FlushCnt_o=1.
REQ-036 Timeout: TIMEOUT=8 with no ack -> Err_o=1 after 8 WAIT cycles, FSM back in IDLE, Err_o sticky until rst_i=0.
REQ-037 Reset: rst_i=0 mid-WAIT -> Mem_Enable_o=0 and counters 0 without a clock edge.
